// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, output imem_req, input imem_ready, input imem_rdata);
  modport slave  (input imem_addr, input imem_req, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32 fetch stage + IF/ID register: one instr/cycle at imem_ready=1, IF/ID loads the edge after a response.
// Backpressure: stallD parks one response in a skid buffer and drops imem_req until it drains.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master imem,
  input  logic          stallD,
  input  logic          flushD,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          hlt,
  output logic [31:0]   instrD,
  output logic [31:0]   pcD,
  output logic [31:0]   pcplus4D,
  output logic          validD,
  output logic          halted
);

  typedef enum logic [1:0] {FETCH, KILL, HALT} fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } fetchEntry_t;

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] pcPlus4;
  fetchEntry_t skidBuf;
  logic        bufValid;
  logic        haltPend;
  logic        rsp;
  logic        pending;
  logic        enterHalt;
  logic        doRedirect;

  assign imem.imem_req  = (state != HALT) && !bufValid && reset;
  assign imem.imem_addr = pc;
  assign pcPlus4        = pc + 32'd4;

  // Halt entry outranks redirect; a redirect alongside hlt is dropped.
  always_comb begin
    rsp        = imem.imem_req && imem.imem_ready;
    pending    = imem.imem_req && !imem.imem_ready;
    enterHalt  = (state != HALT) && haltPend && !pending;
    doRedirect = (state != HALT) && redirect && !hlt && !enterHalt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      tgt      <= '0;
      skidBuf  <= '0;
      bufValid <= 1'b0;
      haltPend <= 1'b0;
      instrD   <= NOP_INSTR;
      pcD      <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      haltPend <= haltPend | hlt;
      if (enterHalt) begin
        state    <= HALT;
        halted   <= 1'b1;
        bufValid <= 1'b0;
        if (flushD) begin
          instrD <= NOP_INSTR;
          validD <= 1'b0;
        end
      end else if (state == HALT) begin
        if (flushD) begin
          instrD <= NOP_INSTR;
          validD <= 1'b0;
        end
      end else if (doRedirect) begin
        instrD   <= NOP_INSTR;
        validD   <= 1'b0;
        bufValid <= 1'b0;
        // An in-flight request must complete at the old address before retargeting.
        if (pending) begin
          tgt   <= redirect_pc;
          state <= KILL;
        end else begin
          pc    <= redirect_pc;
          state <= FETCH;
        end
      end else if (state == KILL) begin
        if (rsp) begin
          pc    <= tgt;
          state <= FETCH;
        end
        if (flushD) begin
          instrD <= NOP_INSTR;
          validD <= 1'b0;
        end
      end else begin
        if (rsp) begin
          pc <= pcPlus4;
          if (!stallD) begin
            instrD   <= imem.imem_rdata;
            pcD      <= pc;
            pcplus4D <= pcPlus4;
            validD   <= 1'b1;
          end else begin
            skidBuf  <= '{instr: imem.imem_rdata, pc: pc, pcPlus4: pcPlus4};
            bufValid <= 1'b1;
            if (flushD) begin
              instrD <= NOP_INSTR;
              validD <= 1'b0;
            end
          end
        end else if (bufValid && !stallD) begin
          instrD   <= skidBuf.instr;
          pcD      <= skidBuf.pc;
          pcplus4D <= skidBuf.pcPlus4;
          validD   <= 1'b1;
          bufValid <= 1'b0;
        end else if (flushD) begin
          instrD <= NOP_INSTR;
          validD <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle tables, async-reset sequence, and a randomized stream check.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        rdy = 1'b0;
  logic        stl = 1'b0;
  logic        fl = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] rpc = '0;
  logic        hl = 1'b0;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        validD, halted;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) + 32'h1234_5678;
  endfunction

  fetch_stage_if imemBus();
  assign imemBus.imem_ready = rdy;
  assign imemBus.imem_rdata = memWord(imemBus.imem_addr);

  fetch_stage dut (
    .clk(clk), .reset(rstN), .imem(imemBus.master),
    .stallD(stl), .flushD(fl), .redirect(rd), .redirect_pc(rpc), .hlt(hl),
    .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD), .halted(halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy, stl, fl, rd, hl;
    logic [31:0] rpc;
    logic [31:0] eAddr;
    logic        eReq, eValid, eHalt;
    logic [31:0] ePcD;
  } vec_t;

  vec_t tabA[$];
  vec_t tabB[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic d,
                              input logic [31:0] p, input logic h, input logic [31:0] ea,
                              input logic eq, input logic ev, input logic eh, input logic [31:0] epc);
    vec_t v;
    v.rdy = r; v.stl = s; v.fl = f; v.rd = d; v.rpc = p; v.hl = h;
    v.eAddr = ea; v.eReq = eq; v.eValid = ev; v.eHalt = eh; v.ePcD = epc;
    return v;
  endfunction

  task automatic applyRow(input vec_t v, input string tag);
    @(negedge clk);
    rdy = v.rdy; stl = v.stl; fl = v.fl; rd = v.rd; rpc = v.rpc; hl = v.hl;
    @(posedge clk);
    #1;
    chk({tag, "_addr"}, imemBus.imem_addr, v.eAddr);
    chk({tag, "_req"}, imemBus.imem_req, v.eReq);
    chk({tag, "_valid"}, validD, v.eValid);
    chk({tag, "_halted"}, halted, v.eHalt);
    if (v.eValid) begin
      chk({tag, "_pcD"}, pcD, v.ePcD);
      chk({tag, "_instr"}, instrD, memWord(v.ePcD));
      chk({tag, "_pc4"}, pcplus4D, v.ePcD + 32'd4);
    end else begin
      chk({tag, "_nop"}, instrD, NOP);
    end
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_addr"}, imemBus.imem_addr, 32'h0);
    chk({tag, "_req"}, imemBus.imem_req, 1'b0);
    chk({tag, "_instr"}, instrD, NOP);
    chk({tag, "_pcD"}, pcD, 32'h0);
    chk({tag, "_pc4"}, pcplus4D, 32'h0);
    chk({tag, "_valid"}, validD, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
  endtask

  logic [31:0] q[$];
  logic [31:0] expNext, oldPc, oldInstr, front;
  logic        oldValid, acc, delivered;

  initial begin
    // sequential fetch, then late ready at 0x10
    for (int i = 0; i < 4; i++) tabA.push_back(mk(1,0,0,0,0,0, 32'h4*(i+1), 1,1,0, 32'h4*i));
    for (int i = 0; i < 3; i++) tabA.push_back(mk(0,0,0,0,0,0, 32'h10, 1,1,0, 32'hC));
    for (int i = 0; i < 4; i++) tabA.push_back(mk(1,0,0,0,0,0, 32'h14+4*i, 1,1,0, 32'h10+4*i));
    // stall while 0x20 arrives
    tabA.push_back(mk(1,1,0,0,0,0, 32'h24, 0,1,0, 32'h1C));
    tabA.push_back(mk(1,1,0,0,0,0, 32'h24, 0,1,0, 32'h1C));
    tabA.push_back(mk(1,0,0,0,0,0, 32'h24, 1,1,0, 32'h20));
    for (int i = 0; i < 7; i++) tabA.push_back(mk(1,0,0,0,0,0, 32'h28+4*i, 1,1,0, 32'h24+4*i));
    // redirect while 0x40 pending
    tabA.push_back(mk(0,0,0,1,32'h100,0, 32'h40, 1,0,0, 0));
    tabA.push_back(mk(0,0,0,0,0,0, 32'h40, 1,0,0, 0));
    tabA.push_back(mk(1,0,0,0,0,0, 32'h100, 1,0,0, 0));
    tabA.push_back(mk(1,0,0,0,0,0, 32'h104, 1,1,0, 32'h100));
    // flush alone, then flush with a response
    tabA.push_back(mk(0,0,1,0,0,0, 32'h104, 1,0,0, 0));
    tabA.push_back(mk(1,0,1,0,0,0, 32'h108, 1,1,0, 32'h104));
    tabA.push_back(mk(1,0,0,0,0,0, 32'h10C, 1,1,0, 32'h108));
    // hlt during a pending request
    tabA.push_back(mk(0,0,0,0,0,1, 32'h10C, 1,1,0, 32'h108));
    tabA.push_back(mk(0,0,0,0,0,0, 32'h10C, 1,1,0, 32'h108));
    tabA.push_back(mk(1,0,0,0,0,0, 32'h10C, 0,1,1, 32'h108));
    tabA.push_back(mk(1,0,0,1,32'h200,0, 32'h10C, 0,1,1, 32'h108));
    tabA.push_back(mk(1,0,1,0,0,0, 32'h10C, 0,0,1, 0));

    // PC wrap, then redirect coinciding with hlt
    tabB.push_back(mk(1,0,0,0,0,0, 32'h4, 1,1,0, 32'h0));
    tabB.push_back(mk(1,0,0,1,32'hFFFF_FFFC,0, 32'hFFFF_FFFC, 1,0,0, 0));
    tabB.push_back(mk(1,0,0,0,0,0, 32'h0, 1,1,0, 32'hFFFF_FFFC));
    tabB.push_back(mk(1,0,0,0,0,0, 32'h4, 1,1,0, 32'h0));
    tabB.push_back(mk(1,0,0,1,32'h300,1, 32'h8, 1,1,0, 32'h4));
    tabB.push_back(mk(1,0,0,0,0,0, 32'h8, 0,1,1, 32'h4));
    tabB.push_back(mk(1,0,0,0,0,0, 32'h8, 0,1,1, 32'h4));

    repeat (2) @(negedge clk);
    checkReset("rst0");
    @(negedge clk);
    rstN = 1'b1;

    foreach (tabA[i]) applyRow(tabA[i], $sformatf("A%0d", i));

    // async reset while halted, landing between clock edges
    @(negedge clk);
    #2 rstN = 1'b0;
    #1 checkReset("rstHalt");
    @(negedge clk);
    rdy = 1'b0; stl = 1'b0; fl = 1'b0; rd = 1'b0; hl = 1'b0;
    rstN = 1'b1;
    #1;
    chk("rel_addr", imemBus.imem_addr, 32'h0);
    chk("rel_req", imemBus.imem_req, 1'b1);

    foreach (tabB[i]) applyRow(tabB[i], $sformatf("B%0d", i));

    // randomized ready/stall against an in-order stream model
    @(negedge clk);
    rstN = 1'b0;
    rdy = 1'b0; stl = 1'b0; fl = 1'b0; rd = 1'b0; hl = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    expNext = 32'h0;
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c < 1490) begin
        rdy = ($urandom_range(0, 3) != 0);
        stl = ($urandom_range(0, 3) == 0);
      end else begin
        rdy = 1'b0;
        stl = 1'b0;
      end
      #1;
      chk("rnd_req", imemBus.imem_req, (q.size() == 0));
      if (imemBus.imem_req) chk("rnd_addr", imemBus.imem_addr, expNext);
      acc = imemBus.imem_req && rdy;
      oldPc = pcD; oldInstr = instrD; oldValid = validD;
      @(posedge clk);
      #1;
      if (acc) begin
        q.push_back(expNext);
        expNext = expNext + 32'd4;
      end
      delivered = validD && (!oldValid || pcD != oldPc);
      chk("rnd_deliver", delivered, !stl && (q.size() > 0));
      if (delivered && q.size() > 0) begin
        front = q.pop_front();
        chk("rnd_pcD", pcD, front);
        chk("rnd_instr", instrD, memWord(front));
        chk("rnd_pc4", pcplus4D, front + 32'd4);
      end
      if (stl) begin
        chk("rnd_holdPc", pcD, oldPc);
        chk("rnd_holdInstr", instrD, oldInstr);
      end
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_progress", (expNext > 32'h400), 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register that feed the pipelined RV32 datapath's decode stage (instrD, pcD, pcplus4D, validD).
- Owns the architectural PC and drives a variable-latency instruction-memory request/ready interface.
- Absorbs decode stalls with a one-entry skid buffer.
- Applies branch/jump redirects resolved in EX, and halts fetch on hlt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in instrD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  32  fetch address; equals the PC register.
- imem_req  output  1  fetch request.
- imem_ready  input  1  response valid; completes the current request.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- stallD  input  1  hazard unit: hold IF/ID contents.
- flushD  input  1  hazard unit: squash IF/ID contents.
- redirect  input  1  EX stage: taken branch or jump.
- redirect_pc  input  32  redirect target; bit 0 already cleared upstream.
- hlt  input  1  stop fetching.
- instrD  output  32  decode-stage instruction.
- pcD  output  32  PC of instrD.
- pcplus4D  output  32  pcD+4.
- validD  output  1  instrD is a real instruction.
- halted  output  1  fetch stopped.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=FETCH, tgt=0, buf_valid=0, halt_pend=0.
  - instrD=NOP_INSTR, pcD=0, pcplus4D=0, validD=0, halted=0.
  - imem_req=0 while reset is low.
- States: FETCH, KILL, HALT.
- imem_req = (state!=HALT) & !buf_valid & reset.
- Request rule: while imem_req=1 and imem_ready=0, imem_addr must not change.
- A response occurs when imem_req=1 and imem_ready=1.
- With imem_ready tied to 1, throughput is one instruction per cycle with zero bubbles.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- FETCH, response, no redirect:
  - stallD=0: IF/ID loads imem_rdata, pc, pc+4; validD=1; pc<=pc+4.
  - stallD=1: imem_rdata, pc and pc+4 go into the skid buffer; buf_valid=1; pc<=pc+4; IF/ID holds.
- Buffer drain: the first cycle with buf_valid=1 and stallD=0 loads IF/ID from the buffer and clears buf_valid. The request resumes the next cycle.
- flushD=1 (no redirect):
  - IF/ID becomes a bubble (instrD=NOP_INSTR, validD=0) unless the same cycle loads a new instruction (response or buffer drain with stallD=0).
  - flushD overrides stallD for IF/ID. The skid buffer is retained.
- Redirect: highest priority in FETCH and KILL; ignored in HALT.
  - IF/ID becomes a bubble and buf_valid is cleared.
  - A response in the same cycle is discarded.
  - If a request is pending (imem_req=1, imem_ready=0): tgt<=redirect_pc, state<=KILL.
  - Otherwise: pc<=redirect_pc, state stays FETCH.
- KILL state:
  - imem_addr holds the old pc.
  - A repeated redirect overwrites tgt.
  - On imem_ready: data is dropped, pc<=tgt, state<=FETCH.
  - stallD/flushD still act on IF/ID.
- hlt:
  - hlt=1 sets halt_pend.
  - Enter HALT when halt_pend=1 and no request is pending. A response arriving that cycle is discarded; IF/ID is not loaded.
  - A redirect in the same cycle as hlt is ignored, and halt proceeds.
  - HALT: imem_req=0, pc frozen, halted=1, skid buffer discarded. IF/ID still obeys stallD/flushD. Exit only via reset.
- Reset mid-transaction: all state is cleared immediately and the outstanding response is ignored. After release, the first request goes to RESET_PC.

Test Plan:
- Reset release, imem_ready=1, sequential memory → imem_addr 0,4,8,… each cycle; validD=1 from the second cycle; pcD=0 with instrD=mem[0]; pcplus4D=4.
- Ready 3 cycles late at pc=0x10 → imem_addr stable at 0x10 for 3 cycles; instrD loads only after ready; no duplicate or lost instruction.
- stallD high 2 cycles while the response at 0x20 arrives → skid buffer holds 0x20; imem_req=0; instrD unchanged; after stallD drops, pcD=0x20 and fetch resumes at 0x24.
- Redirect to 0x100 while a request at 0x40 is pending (ready low 2 cycles) → state KILL; imem_addr stays 0x40; the 0x40 data never reaches ID; next request at 0x100; validD=0 for the bubble.
- flushD pulse with no response, then flushD with a simultaneous response → first: instrD=0x00000013, validD=0; second: the new instruction loads with validD=1.
- hlt during a pending request → halted=1 the cycle after ready; imem_req=0; pc frozen. Async reset while halted → pc=RESET_PC, halted=0 immediately.
